fetch_queue: RTL and testbench

Parametrised multi-lane instruction buffer between `fetch` and `decode`. It decouples the instruction-memory response timing from decode back-pressure. It accepts up to FETCH_W instructions per cycle, compacting sparse valid lanes, and presents the oldest up to DEQ_W instructions in program order. A redirect flush discards all buffered entries in a single cycle.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - multi-lane compacting instruction buffer between fetch and decode
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int FETCH_W = 2,
  parameter int DEQ_W   = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            enq_valid,
  input  logic [FETCH_W-1:0][XLEN-1:0]  enq_pc,
  input  logic [FETCH_W-1:0][XLEN-1:0]  enq_instr,
  output logic                          enq_ready,
  output logic [DEQ_W-1:0]              deq_valid,
  output logic [DEQ_W-1:0][XLEN-1:0]    deq_pc,
  output logic [DEQ_W-1:0][XLEN-1:0]    deq_instr,
  input  logic                          deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (FETCH_W > DEQ_W) ? FETCH_W : DEQ_W;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   enq_n;
  logic [CW-1:0]   deq_n;
  logic [CW-1:0]   skip_n;
  logic [CW-1:0]   store_n;
  logic [CW-1:0]   pre [FETCH_W];
  logic [XLEN-1:0] comp_pc    [LW];
  logic [XLEN-1:0] comp_instr [LW];
  logic            enq_fire;
  logic            bypass;

  // Registered count only, so deq_ready never reaches enq_ready combinationally.
  assign enq_ready = (count <= CW'(DEPTH - FETCH_W));
  assign enq_fire  = enq_ready & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count == '0) & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Compaction: lane j lands in slot pre[j], the number of valid lanes below it.
  always_comb begin
    enq_n = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      pre[j] = enq_n;
      enq_n  = enq_n + CW'(enq_valid[j]);
    end
    for (int k = 0; k < LW; k++) begin
      comp_pc[k]    = '0;
      comp_instr[k] = '0;
      for (int j = 0; j < FETCH_W; j++) begin
        if (enq_valid[j] && pre[j] == CW'(k)) begin
          comp_pc[k]    = enq_pc[j];
          comp_instr[k] = enq_instr[j];
        end
      end
    end
  end

  always_comb begin
    skip_n = '0;
    if (bypass && deq_ready)
      skip_n = (enq_n > CW'(DEQ_W)) ? CW'(DEQ_W) : enq_n;
    store_n = enq_fire ? (enq_n - skip_n) : '0;
  end

  always_comb begin
    deq_n = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i] = 1'b0;
      deq_pc[i]    = '0;
      deq_instr[i] = '0;
      if (bypass) begin
        if (CW'(i) < enq_n) begin
          deq_valid[i] = 1'b1;
          deq_pc[i]    = comp_pc[i];
          deq_instr[i] = comp_instr[i];
        end
      end else if (!flush && count > CW'(i)) begin
        deq_valid[i] = 1'b1;
        deq_pc[i]    = mem_pc[head + PW'(i)];
        deq_instr[i] = mem_instr[head + PW'(i)];
      end
      // Bypassed lanes never entered storage, so they do not move head.
      if (!bypass && deq_ready && deq_valid[i])
        deq_n = deq_n + CW'(1);
    end
  end

  // Lanes consumed by bypass are skipped; the rest pack contiguously from tail.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (enq_fire && CW'(k) >= skip_n && CW'(k) < enq_n) begin
        mem_pc[tail + PW'(CW'(k) - skip_n)]    <= comp_pc[k];
        mem_instr[tail + PW'(CW'(k) - skip_n)] <= comp_instr[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(store_n);
      count <= count + store_n - deq_n;
      if (|enq_valid && !enq_ready)
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [1:0]        enq_valid;
  logic [1:0][31:0]  enq_pc;
  logic [1:0][31:0]  enq_instr;
  logic              enq_ready;
  logic [1:0]        deq_valid;
  logic [1:0][31:0]  deq_pc;
  logic [1:0][31:0]  deq_instr;
  logic              deq_ready;
  logic [3:0]        count;
  logic              ovf_err;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.FETCH_W(2), .DEQ_W(2), .XLEN(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_ready(deq_ready), .count(count), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    enq_valid    = v;
    enq_pc[0]    = p0;
    enq_pc[1]    = p1;
    enq_instr[0] = p0 ^ 32'hFFFF_0000;
    enq_instr[1] = p1 ^ 32'hFFFF_0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    set_enq(2'b00, 32'h0, 32'h0);
    repeat (2) cyc();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL reset_deq_valid: got %b expected 00", deq_valid); end
    checks++; if (deq_pc !== 64'h0) begin errors++; $display("FAIL reset_deq_pc: got %h expected 0", deq_pc); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_err); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_enq(2'b11, 32'h0, 32'h4);
    deq_ready = 1'b1;
    #1;
`ifndef FETCH_QUEUE_BYPASS_EN
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL basic_empty_deq: got %b expected 00", deq_valid); end
`endif
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
`ifndef FETCH_QUEUE_BYPASS_EN
    checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL basic_deq_valid: got %b expected 11", deq_valid); end
    checks++; if (deq_pc[0] !== 32'h0) begin errors++; $display("FAIL basic_pc0: got %h expected 0", deq_pc[0]); end
    checks++; if (deq_pc[1] !== 32'h4) begin errors++; $display("FAIL basic_pc1: got %h expected 4", deq_pc[1]); end
    checks++; if (deq_instr[1] !== 32'hFFFF_0004) begin errors++; $display("FAIL basic_instr1: got %h expected ffff0004", deq_instr[1]); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", count); end
`endif
    cyc();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_drained: got %0d expected 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL basic_after_deq: got %b expected 00", deq_valid); end
    deq_ready = 1'b0;
  endtask

  task automatic test_sparse();
    set_enq(2'b10, 32'h99, 32'h14);
    deq_ready = 1'b0;
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL sparse_valid: got %b expected 01", deq_valid); end
    checks++; if (deq_pc[0] !== 32'h14) begin errors++; $display("FAIL sparse_pc0: got %h expected 14", deq_pc[0]); end
    checks++; if (deq_pc[1] !== 32'h0) begin errors++; $display("FAIL sparse_pc1_zero: got %h expected 0", deq_pc[1]); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL sparse_count: got %0d expected 1", count); end
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL sparse_drain: got %0d expected 0", count); end
  endtask

  task automatic test_fill_overflow();
    deq_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_enq(2'b11, 32'h100 + 32'(8 * c), 32'h104 + 32'(8 * c));
      cyc();
    end
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_enq_ready: got %b expected 0", enq_ready); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_ovf_early: got %b expected 0", ovf_err); end
    set_enq(2'b11, 32'h200, 32'h204);
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf_err); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
    deq_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (deq_pc[0] !== 32'h100 + 32'(8 * c)) begin errors++; $display("FAIL drain_pc0[%0d]: got %h expected %h", c, deq_pc[0], 32'h100 + 32'(8 * c)); end
      checks++; if (deq_pc[1] !== 32'h104 + 32'(8 * c)) begin errors++; $display("FAIL drain_pc1[%0d]: got %h expected %h", c, deq_pc[1], 32'h104 + 32'(8 * c)); end
      cyc();
    end
    deq_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] mq[$];
    logic [31:0] next_pc;
    logic        ev;
    logic        dr;
    logic [31:0] exp_pc;
    next_pc = 32'h1000;
    for (int c = 0; c < 24; c++) begin
      dr = (c >= 20) ? 1'b1 : c[0];
      ev = (c < 20) && (mq.size() <= 6);
      deq_ready = dr;
      set_enq(ev ? 2'b11 : 2'b00, next_pc, next_pc + 32'h4);
      #1;
      checks++; if (enq_ready !== (mq.size() <= 6)) begin errors++; $display("FAIL wrap_enq_ready[%0d]: got %b expected %b", c, enq_ready, mq.size() <= 6); end
      checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", c, count, mq.size()); end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (mq.size() != 0)
`endif
      for (int i = 0; i < 2; i++) begin
        exp_pc = (mq.size() > i) ? mq[i] : 32'h0;
        checks++; if (deq_valid[i] !== (mq.size() > i)) begin errors++; $display("FAIL wrap_valid[%0d][%0d]: got %b expected %b", c, i, deq_valid[i], mq.size() > i); end
        checks++; if (deq_pc[i] !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d][%0d]: got %h expected %h", c, i, deq_pc[i], exp_pc); end
      end
      cyc();
      if (dr) begin
        for (int i = 0; i < 2; i++)
          if (mq.size() > 0) void'(mq.pop_front());
      end
      if (ev) begin
        mq.push_back(next_pc);
        mq.push_back(next_pc + 32'h4);
        next_pc = next_pc + 32'h8;
      end
    end
    set_enq(2'b00, 32'h0, 32'h0);
    deq_ready = 1'b0;
    #1;
    checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL wrap_final_count: got %0d expected %0d", count, mq.size()); end
    while (mq.size() > 0) begin
      deq_ready = 1'b1;
      cyc();
      for (int i = 0; i < 2; i++)
        if (mq.size() > 0) void'(mq.pop_front());
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_flush();
    deq_ready = 1'b0;
    set_enq(2'b11, 32'h600, 32'h604);
    cyc();
    set_enq(2'b11, 32'h608, 32'h60C);
    cyc();
    set_enq(2'b01, 32'h610, 32'h0);
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    flush = 1'b1;
    deq_ready = 1'b1;
    set_enq(2'b11, 32'h300, 32'h304);
    #1;
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL flush_deq_valid: got %b expected 00", deq_valid); end
    checks++; if (deq_pc[0] !== 32'h0) begin errors++; $display("FAIL flush_deq_pc: got %h expected 0", deq_pc[0]); end
    cyc();
    flush = 1'b0;
    deq_ready = 1'b0;
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL flush_empty: got %b expected 00", deq_valid); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
    set_enq(2'b11, 32'h400, 32'h404);
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (deq_pc[0] !== 32'h400) begin errors++; $display("FAIL post_flush_pc0: got %h expected 400", deq_pc[0]); end
    checks++; if (deq_pc[1] !== 32'h404) begin errors++; $display("FAIL post_flush_pc1: got %h expected 404", deq_pc[1]); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL post_flush_count: got %0d expected 2", count); end
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_enq(2'b11, 32'h700, 32'h704);
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL mid_pre_count: got %0d expected 2", count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_async_count: got %0d expected 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL mid_async_valid: got %b expected 00", deq_valid); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL mid_async_ovf: got %b expected 0", ovf_err); end
    reset = 1'b0;
    set_enq(2'b10, 32'h0, 32'h800);
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    #1;
    checks++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL mid_after_valid: got %b expected 01", deq_valid); end
    checks++; if (deq_pc[0] !== 32'h800) begin errors++; $display("FAIL mid_after_pc: got %h expected 800", deq_pc[0]); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", count); end
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    set_enq(2'b11, 32'h40, 32'h44);
    deq_ready = 1'b1;
    #1;
    checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL bypass_valid: got %b expected 11", deq_valid); end
    checks++; if (deq_pc[0] !== 32'h40) begin errors++; $display("FAIL bypass_pc0: got %h expected 40", deq_pc[0]); end
    checks++; if (deq_pc[1] !== 32'h44) begin errors++; $display("FAIL bypass_pc1: got %h expected 44", deq_pc[1]); end
    cyc();
    set_enq(2'b00, 32'h0, 32'h0);
    deq_ready = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_fill_overflow();
    test_wrap();
    test_flush();
    test_reset_mid();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
